// File: rtl/poly_datapath.sv
// Quadratic-evaluation datapath: one saturating multiply/add unit,
// two accumulators and a registered result, driven by an external FSM.
//
// Ports:
//   clk, reset (async, active-low)
//   load_en, x_in, coef_a, coef_b, coef_c : operand capture
//   Constant_control, M_S_I0_control, M_S_I1_control, MS_control : unit controls
//   Acc0_en, Acc1_en : accumulator write enables
//   OR_en : load result from Acc0
//   result, result_valid, error : registered outputs
module poly_datapath #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_en,
    input  logic [WORD_LENGTH-1:0] x_in,
    input  logic [WORD_LENGTH-1:0] coef_a,
    input  logic [WORD_LENGTH-1:0] coef_b,
    input  logic [WORD_LENGTH-1:0] coef_c,
    input  logic [1:0]             Constant_control,
    input  logic [1:0]             M_S_I0_control,
    input  logic [1:0]             M_S_I1_control,
    input  logic                   MS_control,
    input  logic                   Acc0_en,
    input  logic                   Acc1_en,
    input  logic                   OR_en,
    output logic [WORD_LENGTH-1:0] result,
    output logic                   result_valid,
    output logic                   error
);

    localparam int W  = WORD_LENGTH;
    localparam int W2 = 2 * WORD_LENGTH;

    localparam logic [W2-1:0] MAX_WIDE = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic [W2-1:0] MIN_WIDE = {{(W + 1){1'b1}}, {(W - 1){1'b0}}};
    localparam logic [W-1:0]  MAX_OUT  = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0]  MIN_OUT  = {1'b1, {(W - 1){1'b0}}};

    logic [W-1:0]  x_q, a_q, b_q, c_q;
    logic [W-1:0]  acc0, acc1;
    logic          ovf_s;

    logic [W-1:0]  const_v;
    logic [W-1:0]  in0, in1;
    logic [W2-1:0] ext0, ext1;
    logic [W2-1:0] full;
    logic [W-1:0]  unit_out;
    logic          ovf_now;

    always_comb begin
        const_v = '0;
        unique case (Constant_control)
            2'b00: const_v = c_q;
            2'b01: const_v = b_q;
            2'b10: const_v = a_q;
            2'b11: const_v = '0;
        endcase
    end

    always_comb begin
        in0 = '0;
        unique case (M_S_I0_control)
            2'b00: in0 = const_v;
            2'b01: in0 = x_q;
            2'b10: in0 = acc0;
            2'b11: in0 = '0;
        endcase
    end

    always_comb begin
        in1 = '0;
        unique case (M_S_I1_control)
            2'b00: in1 = x_q;
            2'b01: in1 = acc0;
            2'b10: in1 = acc1;
            2'b11: in1 = '0;
        endcase
    end

    // Both operands are sign-extended to 2W bits; a W x W signed product and a
    // W-bit signed sum both fit there exactly, so one range check covers both.
    assign ext0 = {{W{in0[W-1]}}, in0};
    assign ext1 = {{W{in1[W-1]}}, in1};
    assign full = MS_control ? (ext0 + ext1) : (ext0 * ext1);

    always_comb begin
        unit_out = full[W-1:0];
        ovf_now  = 1'b0;
        if ($signed(full) > $signed(MAX_WIDE)) begin
            unit_out = MAX_OUT;
            ovf_now  = 1'b1;
        end else if ($signed(full) < $signed(MIN_WIDE)) begin
            unit_out = MIN_OUT;
            ovf_now  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (load_en) begin
            x_q <= x_in;
            a_q <= coef_a;
            b_q <= coef_b;
            c_q <= coef_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc0 <= '0;
            acc1 <= '0;
        end else begin
            if (Acc0_en) acc0 <= unit_out;
            if (Acc1_en) acc1 <= unit_out;
        end
    end

    // A new load starts a fresh evaluation, so clearing beats a same-cycle set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_s <= 1'b0;
        end else if (load_en) begin
            ovf_s <= 1'b0;
        end else if (ovf_now && (Acc0_en || Acc1_en)) begin
            ovf_s <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result       <= '0;
            error        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= OR_en;
            if (OR_en) begin
                result <= acc0;
                error  <= ovf_s;
            end
        end
    end

endmodule

// File: tb/tb_poly_datapath.sv
// Self-checking bench for poly_datapath: directed scenarios plus random
// full evaluations against an integer polynomial model with per-step clamping.
module tb_poly_datapath;

    localparam int W    = 8;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_en = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] coef_a = '0;
    logic [W-1:0] coef_b = '0;
    logic [W-1:0] coef_c = '0;
    logic [1:0]   Constant_control = '0;
    logic [1:0]   M_S_I0_control = '0;
    logic [1:0]   M_S_I1_control = '0;
    logic         MS_control = 1'b0;
    logic         Acc0_en = 1'b0;
    logic         Acc1_en = 1'b0;
    logic         OR_en = 1'b0;
    logic [W-1:0] result;
    logic         result_valid;
    logic         error;

    int checks = 0;
    int errors = 0;

    poly_datapath #(.WORD_LENGTH(W)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .x_in             (x_in),
        .coef_a           (coef_a),
        .coef_b           (coef_b),
        .coef_c           (coef_c),
        .Constant_control (Constant_control),
        .M_S_I0_control   (M_S_I0_control),
        .M_S_I1_control   (M_S_I1_control),
        .MS_control       (MS_control),
        .Acc0_en          (Acc0_en),
        .Acc1_en          (Acc1_en),
        .OR_en            (OR_en),
        .result           (result),
        .result_valid     (result_valid),
        .error            (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, inout bit e);
        if (v > MAXV) begin
            e = 1'b1;
            return MAXV;
        end
        if (v < MINV) begin
            e = 1'b1;
            return MINV;
        end
        return v;
    endfunction

    // y = a*x^2 + b*x + c, each intermediate clamped to the word range.
    function automatic void model(input int x, input int a, input int b,
                                  input int c, output int y, output bit e);
        int sq, ax2, bx, s;
        e   = 1'b0;
        sq  = clamp(x * x, e);
        ax2 = clamp(a * sq, e);
        bx  = clamp(b * x, e);
        s   = clamp(ax2 + bx, e);
        y   = clamp(s + c, e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        load_en          = 1'b0;
        Constant_control = 2'b00;
        M_S_I0_control   = 2'b00;
        M_S_I1_control   = 2'b00;
        MS_control       = 1'b0;
        Acc0_en          = 1'b0;
        Acc1_en          = 1'b0;
        OR_en            = 1'b0;
    endtask

    task automatic set_ops(input int x, input int a, input int b, input int c);
        x_in   = W'(x);
        coef_a = W'(a);
        coef_b = W'(b);
        coef_c = W'(c);
    endtask

    task automatic load(input int x, input int a, input int b, input int c);
        set_ops(x, a, b, c);
        load_en = 1'b1;
        tick();
        clear_ctl();
    endtask

    task automatic ctl(input logic [1:0] k, input logic [1:0] s0,
                       input logic [1:0] s1, input logic ms,
                       input logic a0, input logic a1, input logic orr);
        Constant_control = k;
        M_S_I0_control   = s0;
        M_S_I1_control   = s1;
        MS_control       = ms;
        Acc0_en          = a0;
        Acc1_en          = a1;
        OR_en            = orr;
        tick();
        clear_ctl();
    endtask

    task automatic steps_1_to_3();
        ctl(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        ctl(2'b10, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        ctl(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic steps_4_5();
        ctl(2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        ctl(2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic read_out(input string tag, input int exp_y, input bit exp_e);
        ctl(2'b11, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
        check({tag, "_valid"}, int'(result_valid), 1);
        check({tag, "_result"}, int'($signed(result)), exp_y);
        check({tag, "_error"}, int'(error), int'(exp_e));
    endtask

    task automatic evaluate(input string tag, input int x, input int a,
                            input int b, input int c, input int n_or);
        int y;
        bit e;
        model(x, a, b, c, y, e);
        load(x, a, b, c);
        steps_1_to_3();
        steps_4_5();
        check({tag, "_novalid"}, int'(result_valid), 0);
        for (int i = 0; i < n_or; i++) read_out(tag, y, e);
        tick();
        check({tag, "_pulse_end"}, int'(result_valid), 0);
    endtask

    initial begin
        int rx, ra, rb, rc;

        tick();
        tick();
        check("rst_result", int'(result), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_error", int'(error), 0);
        reset = 1'b1;
        tick();

        evaluate("basic", 3, 2, -1, 5, 2);
        check("basic_value", int'($signed(result)), 20);
        evaluate("negative", -4, -1, 3, 7, 1);
        evaluate("ovf", 20, 1, 0, 0, 1);
        evaluate("recover", 1, 1, 1, 1, 1);
        evaluate("negsat", 10, -2, 0, 0, 1);

        // Select code 11 paths and dual accumulator write.
        load(5, 0, 0, 0);
        ctl(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
        read_out("dual_acc0", 25, 1'b0);
        ctl(2'b00, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
        read_out("zero_add", 0, 1'b0);
        ctl(2'b00, 2'b11, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        read_out("dual_acc1", 25, 1'b0);
        ctl(2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        read_out("zero_const", 0, 1'b0);

        // Load concurrent with a compute step: step sees old x.
        load(20, 0, 0, 0);
        set_ops(9, 0, 0, 0);
        load_en = 1'b1;
        ctl(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        read_out("load_clear_wins", MAXV, 1'b0);
        ctl(2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        read_out("new_operand", 81, 1'b0);

        // Overflow without an accumulator write must not set the flag.
        load(20, 0, 0, 0);
        ctl(2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        read_out("no_write_ovf", 81, 1'b0);

        // Reset mid-sequence after a saturated result.
        evaluate("pre_rst", 10, -2, 0, 0, 1);
        load(3, 2, -1, 5);
        steps_1_to_3();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_result", int'(result), 0);
        check("midrst_valid", int'(result_valid), 0);
        check("midrst_error", int'(error), 0);
        tick();
        reset = 1'b1;
        tick();
        check("postrst_valid", int'(result_valid), 0);
        evaluate("after_rst", 3, 2, -1, 5, 1);

        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                rx = int'($urandom_range(0, 15)) - 8;
                ra = int'($urandom_range(0, 7)) - 4;
                rb = int'($urandom_range(0, 15)) - 8;
                rc = int'($urandom_range(0, 63)) - 32;
            end else begin
                rx = int'($urandom_range(0, 255)) + MINV;
                ra = int'($urandom_range(0, 255)) + MINV;
                rb = int'($urandom_range(0, 255)) + MINV;
                rc = int'($urandom_range(0, 255)) + MINV;
            end
            evaluate($sformatf("rand%0d", i), rx, ra, rb, rc, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
